// File: rtl/poke_pkg.sv
// Shared types and constants for the poke_game player movement logic.
package poke_pkg;

    // Tile edge in pixels; shared with the level ROM.
    localparam int unsigned TILE_PX = 16;
    localparam int unsigned TILE_W  = 6;
    localparam int unsigned ADDR_W  = 12;
    localparam int unsigned PX_W    = 11;
    localparam int unsigned PY_W    = 10;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        MOVE   = 2'd2
    } move_state_t;

    typedef struct packed {
        logic [TILE_W-1:0] tx;
        logic [TILE_W-1:0] ty;
    } tile_pos_t;

    // D-pad priority: up > down > left > right.
    function automatic dir_t pick_dir(input logic up, input logic down,
                                      input logic left, input logic right);
        dir_t d;
        d = DIR_RIGHT;
        if (up)        d = DIR_UP;
        else if (down) d = DIR_DOWN;
        else if (left) d = DIR_LEFT;
        else if (right) d = DIR_RIGHT;
        return d;
    endfunction

endpackage

// File: rtl/grid_target_calc.sv
// Neighbour-tile calculator: direction + current tile -> target tile, bounds flag, map address.
module grid_target_calc
    import poke_pkg::*;
#(
    parameter int unsigned MAP_W = 64,
    parameter int unsigned MAP_H = 48
) (
    input  dir_t                dir,
    input  tile_pos_t           cur,
    output tile_pos_t           tgt_c,
    output logic                in_bounds_c,
    output logic [ADDR_W-1:0]   addr_c
);

    localparam int unsigned TW1 = TILE_W + 1;

    logic [TILE_W:0] nx;
    logic [TILE_W:0] ny;

    // One extra bit on each coordinate so the +1 at the far edge is visible to the range check.
    always_comb begin
        nx          = {1'b0, cur.tx};
        ny          = {1'b0, cur.ty};
        in_bounds_c = 1'b1;
        case (dir)
            DIR_UP: begin
                if (cur.ty == '0) in_bounds_c = 1'b0;
                else              ny = ny - TW1'(1);
            end
            DIR_DOWN:  ny = ny + TW1'(1);
            DIR_LEFT: begin
                if (cur.tx == '0) in_bounds_c = 1'b0;
                else              nx = nx - TW1'(1);
            end
            default:   nx = nx + TW1'(1);
        endcase
        if (nx >= TW1'(MAP_W) || ny >= TW1'(MAP_H)) in_bounds_c = 1'b0;
        tgt_c.tx = nx[TILE_W-1:0];
        tgt_c.ty = ny[TILE_W-1:0];
        addr_c   = ADDR_W'(ny) * ADDR_W'(MAP_W) + ADDR_W'(nx);
    end

endmodule

// File: rtl/grid_move_controller.sv
// Tile-grid movement sequencer: per-frame d-pad sampling, tile solidity lookup, glide one tile.
module grid_move_controller
    import poke_pkg::*;
#(
    parameter int unsigned TILE_SIZE = TILE_PX,
    parameter int unsigned STEP_PX   = 2,
    parameter int unsigned MAP_W     = 64,
    parameter int unsigned MAP_H     = 48,
    parameter int unsigned START_TX  = 2,
    parameter int unsigned START_TY  = 2
) (
    input  logic                vclk_in,
    input  logic                rst_n_in,
    input  logic                up_in,
    input  logic                down_in,
    input  logic                left_in,
    input  logic                right_in,
    input  logic [10:0]         hcount_in,
    input  logic [9:0]          vcount_in,
    output logic                tile_req_out,
    output logic [ADDR_W-1:0]   tile_addr_out,
    input  logic                tile_ack_in,
    input  logic                tile_solid_in,
    output logic [PX_W-1:0]     player_x,
    output logic [PY_W-1:0]     player_y,
    output logic [1:0]          facing_out,
    output logic                moving_out
);

    localparam int unsigned TILE_SHIFT = $clog2(TILE_SIZE);
    localparam int unsigned STEPS      = TILE_SIZE / STEP_PX;
    localparam int unsigned CNT_W      = (STEPS > 1) ? $clog2(STEPS) : 1;

    localparam logic [1:0] ST_IDLE   = IDLE;
    localparam logic [1:0] ST_LOOKUP = LOOKUP;
    localparam logic [1:0] ST_MOVE   = MOVE;

    logic [1:0]          state,     state_nxt;
    tile_pos_t           cur,       cur_nxt;
    tile_pos_t           tgt,       tgt_nxt;
    logic [CNT_W-1:0]    cnt,       cnt_nxt;
    logic [PX_W-1:0]     px_nxt;
    logic [PY_W-1:0]     py_nxt;
    logic [1:0]          facing_nxt;
    logic                req_nxt;
    logic [ADDR_W-1:0]   addr_nxt;
    logic                moving_nxt;

    logic                frame_tick_c;
    logic                any_pad_c;
    dir_t                pad_dir_c;
    tile_pos_t           calc_tgt_c;
    logic                calc_in_bounds_c;
    logic [ADDR_W-1:0]   calc_addr_c;

    assign frame_tick_c = (hcount_in == 11'd0) && (vcount_in == 10'd0);
    assign any_pad_c    = up_in | down_in | left_in | right_in;
    assign pad_dir_c    = pick_dir(up_in, down_in, left_in, right_in);

    grid_target_calc #(
        .MAP_W (MAP_W),
        .MAP_H (MAP_H)
    ) u_calc (
        .dir         (pad_dir_c),
        .cur         (cur),
        .tgt_c       (calc_tgt_c),
        .in_bounds_c (calc_in_bounds_c),
        .addr_c      (calc_addr_c)
    );

    // Next-state and next-output decode.
    always_comb begin
        state_nxt  = state;
        cur_nxt    = cur;
        tgt_nxt    = tgt;
        cnt_nxt    = cnt;
        px_nxt     = player_x;
        py_nxt     = player_y;
        facing_nxt = facing_out;
        req_nxt    = tile_req_out;
        addr_nxt   = tile_addr_out;
        moving_nxt = moving_out;
        case (state)
            ST_IDLE: begin
                if (frame_tick_c && any_pad_c) begin
                    facing_nxt = pad_dir_c;
                    if (calc_in_bounds_c) begin
                        state_nxt = ST_LOOKUP;
                        req_nxt   = 1'b1;
                        addr_nxt  = calc_addr_c;
                        tgt_nxt   = calc_tgt_c;
                    end
                end
            end
            ST_LOOKUP: begin
                if (tile_ack_in) begin
                    req_nxt = 1'b0;
                    if (tile_solid_in) begin
                        state_nxt = ST_IDLE;
                    end else begin
                        state_nxt  = ST_MOVE;
                        moving_nxt = 1'b1;
                        cnt_nxt    = '0;
                    end
                end
            end
            ST_MOVE: begin
                if (frame_tick_c) begin
                    case (facing_out)
                        DIR_UP:   py_nxt = player_y - PY_W'(STEP_PX);
                        DIR_DOWN: py_nxt = player_y + PY_W'(STEP_PX);
                        DIR_LEFT: px_nxt = player_x - PX_W'(STEP_PX);
                        default:  px_nxt = player_x + PX_W'(STEP_PX);
                    endcase
                    cnt_nxt = cnt + CNT_W'(1);
                    if (cnt == CNT_W'(STEPS - 1)) begin
                        state_nxt  = ST_IDLE;
                        moving_nxt = 1'b0;
                        cur_nxt    = tgt;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State and output registers; reset places the sprite on the start tile.
    always_ff @(posedge vclk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state         <= ST_IDLE;
            cur           <= '{tx: TILE_W'(START_TX), ty: TILE_W'(START_TY)};
            tgt           <= '{tx: TILE_W'(START_TX), ty: TILE_W'(START_TY)};
            cnt           <= '0;
            player_x      <= PX_W'(START_TX << TILE_SHIFT);
            player_y      <= PY_W'(START_TY << TILE_SHIFT);
            facing_out    <= DIR_DOWN;
            tile_req_out  <= 1'b0;
            tile_addr_out <= '0;
            moving_out    <= 1'b0;
        end else begin
            state         <= state_nxt;
            cur           <= cur_nxt;
            tgt           <= tgt_nxt;
            cnt           <= cnt_nxt;
            player_x      <= px_nxt;
            player_y      <= py_nxt;
            facing_out    <= facing_nxt;
            tile_req_out  <= req_nxt;
            tile_addr_out <= addr_nxt;
            moving_out    <= moving_nxt;
        end
    end

endmodule

// File: tb/tb_grid_move_controller.sv
// Scoreboard bench for grid_move_controller: every change of the output bundle is checked in order.
module tb_grid_move_controller;
    import poke_pkg::*;

    localparam int FRAME = 100;

    logic        clk;
    logic        rst_n;
    logic        up, down, left, right;
    logic [10:0] hcount;
    logic [9:0]  vcount;
    logic        tile_ack, tile_solid;
    logic        tile_req;
    logic [11:0] tile_addr;
    logic [10:0] player_x;
    logic [9:0]  player_y;
    logic [1:0]  facing;
    logic        moving;

    typedef struct packed {
        logic [10:0] x;
        logic [9:0]  y;
        logic [1:0]  f;
        logic        req;
        logic [11:0] addr;
        logic        mv;
    } snap_t;

    snap_t q[$];
    int    n_checks = 0;
    int    n_fail   = 0;
    int    ack_delay = 1;
    logic  solid_val = 1'b0;
    logic  mon_en = 1'b0;
    int    bx = 2, by = 2, baddr = 0;
    logic [1:0] bfacing = 2'd1;

    grid_move_controller dut (
        .vclk_in       (clk),
        .rst_n_in      (rst_n),
        .up_in         (up),
        .down_in       (down),
        .left_in       (left),
        .right_in      (right),
        .hcount_in     (hcount),
        .vcount_in     (vcount),
        .tile_req_out  (tile_req),
        .tile_addr_out (tile_addr),
        .tile_ack_in   (tile_ack),
        .tile_solid_in (tile_solid),
        .player_x      (player_x),
        .player_y      (player_y),
        .facing_out    (facing),
        .moving_out    (moving)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic snap_t mk(input int x, input int y, input logic [1:0] f,
                                 input logic rq, input int a, input logic mv);
        snap_t s;
        s.x = 11'(x); s.y = 10'(y); s.f = f; s.req = rq; s.addr = 12'(a); s.mv = mv;
        return s;
    endfunction

    function automatic snap_t snap();
        snap_t s;
        s.x = player_x; s.y = player_y; s.f = facing; s.req = tile_req;
        s.addr = tile_addr; s.mv = moving;
        return s;
    endfunction

    task automatic check(input string name, input snap_t act, input snap_t exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got x=%0d y=%0d f=%0d req=%0b addr=%0d mv=%0b, want x=%0d y=%0d f=%0d req=%0b addr=%0d mv=%0b",
                     name, act.x, act.y, act.f, act.req, act.addr, act.mv,
                     exp.x, exp.y, exp.f, exp.req, exp.addr, exp.mv);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    // Short synthetic frame: tick only at fc==0; hcount also returns to 0 with vcount!=0.
    initial begin
        int fc;
        fc = 1;
        hcount = 11'd1;
        vcount = 10'd0;
        forever begin
            @(negedge clk);
            fc = (fc == FRAME - 1) ? 0 : fc + 1;
            hcount = 11'(fc % 10);
            vcount = 10'(fc / 10);
        end
    end

    // Tile map responder: ack after ack_delay cycles of req; solid is only meaningful with ack.
    initial begin
        int w;
        w = 0;
        tile_ack = 1'b0;
        tile_solid = 1'b0;
        forever begin
            @(negedge clk);
            tile_ack = 1'b0;
            tile_solid = ~solid_val;
            if (tile_req === 1'b1) begin
                if (w == ack_delay) begin
                    tile_ack = 1'b1;
                    tile_solid = solid_val;
                end
                w++;
            end else begin
                w = 0;
            end
        end
    end

    // Monitor: any change in the output bundle must match the next expected entry.
    initial begin
        snap_t prev, cur;
        prev = '0;
        forever begin
            @(negedge clk);
            cur = snap();
            if (mon_en && cur !== prev) begin
                if (q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_change: got x=%0d y=%0d f=%0d req=%0b addr=%0d mv=%0b, want no change",
                             cur.x, cur.y, cur.f, cur.req, cur.addr, cur.mv);
                end else begin
                    check("output_change", cur, q.pop_front());
                end
            end
            prev = cur;
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish, want finish");
        $fatal(1, "watchdog");
    end

    task automatic next_tick();
        int n;
        n = 0;
        do begin
            @(posedge clk);
            n++;
        end while (!(hcount == 11'd0 && vcount == 10'd0) && n < FRAME + 5);
        if (n >= FRAME + 5) check_int("frame_tick_timeout", n, FRAME);
        #1;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n;
        n = 0;
        while (q.size() != 0 && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        check_int(name, q.size(), 0);
        q.delete();
    endtask

    // Press a button set for one tick and queue the expected bundle sequence.
    task automatic do_move(input logic u, input logic d, input logic l, input logic r,
                           input logic [1:0] edir, input logic solid, input int delay,
                           input string name);
        int sx, sy, tx, ty;
        sx = 0; sy = 0;
        case (edir)
            2'd0: sy = -1;
            2'd1: sy = 1;
            2'd2: sx = -1;
            default: sx = 1;
        endcase
        tx = bx + sx;
        ty = by + sy;
        if (tx >= 0 && tx < 64 && ty >= 0 && ty < 48) begin
            baddr = ty * 64 + tx;
            q.push_back(mk(bx * 16, by * 16, edir, 1'b1, baddr, 1'b0));
            q.push_back(mk(bx * 16, by * 16, edir, 1'b0, baddr, ~solid));
            if (!solid) begin
                for (int i = 1; i <= 8; i++)
                    q.push_back(mk(bx * 16 + sx * 2 * i, by * 16 + sy * 2 * i, edir, 1'b0, baddr, i < 8));
                bx = tx;
                by = ty;
            end
        end else if (edir != bfacing) begin
            q.push_back(mk(bx * 16, by * 16, edir, 1'b0, baddr, 1'b0));
        end
        bfacing = edir;
        solid_val = solid;
        ack_delay = delay;
        up = u; down = d; left = l; right = r;
        next_tick();
        up = 0; down = 0; left = 0; right = 0;
        wait_drain(name, delay + 12 * FRAME);
    endtask

    task automatic apply_reset(input string name);
        q.push_back(mk(32, 32, 2'd1, 1'b0, 0, 1'b0));
        #3;
        rst_n = 1'b0;
        #1;
        check(name, snap(), mk(32, 32, 2'd1, 1'b0, 0, 1'b0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        bx = 2; by = 2; baddr = 0; bfacing = 2'd1;
        wait_drain({name, "_seen"}, 4);
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        up = 0; down = 0; left = 0; right = 0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", snap(), mk(32, 32, 2'd1, 1'b0, 0, 1'b0));
        mon_en = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;

        // Idle for three frames with no input.
        repeat (3) next_tick();
        @(negedge clk); #1;
        check("idle_3_frames", snap(), mk(32, 32, 2'd1, 1'b0, 0, 1'b0));

        // Glide right one tile, ack one cycle after req.
        do_move(0, 0, 0, 1, 2'd3, 1'b0, 1, "right_glide");
        check_int("right_final_x", player_x, 48);

        // Solid tile above: facing changes, nothing moves; ack in the first req cycle.
        do_move(1, 0, 0, 0, 2'd0, 1'b1, 0, "up_solid");

        apply_reset("reset_after_solid");

        // Up has priority over right.
        do_move(1, 0, 0, 1, 2'd0, 1'b0, 3, "up_right_glide");
        check_int("up_right_final_y", player_y, 16);

        // Long ack across many frame ticks, then reset mid-glide.
        ack_delay = 2000;
        solid_val = 1'b0;
        q.push_back(mk(32, 16, 2'd2, 1'b1, 65, 1'b0));
        left = 1;
        next_tick();
        left = 0;
        repeat (1000) @(negedge clk);
        #1;
        check_int("req_held", tile_req, 1);
        check_int("addr_stable", tile_addr, 65);
        q.push_back(mk(32, 16, 2'd2, 1'b0, 65, 1'b1));
        q.push_back(mk(30, 16, 2'd2, 1'b0, 65, 1'b1));
        q.push_back(mk(28, 16, 2'd2, 1'b0, 65, 1'b1));
        q.push_back(mk(26, 16, 2'd2, 1'b0, 65, 1'b1));
        n = 0;
        while (moving !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check_int("delayed_ack_move_start", moving, 1);
        repeat (3) next_tick();
        wait_drain("partial_glide", 5);
        apply_reset("reset_mid_move");

        // Walk to the left edge, turn up against a wall, then try to leave the map.
        ack_delay = 1;
        do_move(0, 0, 1, 0, 2'd2, 1'b0, 1, "left_1");
        do_move(0, 0, 1, 0, 2'd2, 1'b0, 2, "left_2");
        do_move(1, 0, 0, 0, 2'd0, 1'b1, 1, "edge_up_solid");
        do_move(0, 0, 1, 0, 2'd2, 1'b0, 1, "edge_left_off_map");
        left = 1;
        repeat (3) next_tick();
        left = 0;
        @(negedge clk); #1;
        check("edge_no_move", snap(), mk(0, 32, 2'd2, 1'b0, 64, 1'b0));

        repeat (5) @(negedge clk);
        wait_drain("final_queue", 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
